// File: rtl/seg_disp_ctrl.sv
// rtl/seg_disp_ctrl.sv - seven-segment display source arbiter with frame-synchronous commit
//
// Decides who owns an 8-digit hex display (idle, switch echo, or CPU write)
// and hands the chosen value to the scanner only at frame boundaries.
//
// Optional feature: define SEG_LZB_EN to blank leading-zero digits at commit.
//
// Ports:
//   clk              - clock, all state on rising edge
//   rst              - asynchronous active-high reset
//   SwitchCtrl       - switch-echo request (level)
//   io_read_dataP5R1 - 16-bit switch value to echo
//   IOWrite          - CPU write strobe, one cycle per write
//   io_wdata         - CPU write data, sampled with IOWrite
//   frame_tick       - one-cycle pulse at the start of each scan frame
//   disp_data        - 8 hex nibbles to the scanner, digit 0 = [3:0]
//   digit_en         - per-digit enable, bit i lights digit i
//   disp_src         - current owner: 00 idle, 01 switch, 10 CPU
//   pending          - shadow holds a value not yet committed to disp_data
module seg_disp_ctrl #(
  parameter logic [31:0] HOLD_CYCLES = 32'd100_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SwitchCtrl,
  input  logic [15:0] io_read_dataP5R1,
  input  logic        IOWrite,
  input  logic [31:0] io_wdata,
  input  logic        frame_tick,
  output logic [31:0] disp_data,
  output logic [7:0]  digit_en,
  output logic [1:0]  disp_src,
  output logic        pending
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_SW   = 2'b01;
  localparam logic [1:0] ST_CPU  = 2'b10;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [31:0] hold_cnt;
  logic [31:0] hold_cnt_nxt;
  logic [31:0] shadow;
  logic [31:0] shadow_nxt;
  logic [7:0]  en_nxt;

  // A write always wins, from any state, even against a switch request.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (IOWrite)         state_nxt = ST_CPU;
        else if (SwitchCtrl) state_nxt = ST_SW;
      end
      ST_SW: begin
        if (IOWrite)          state_nxt = ST_CPU;
        else if (!SwitchCtrl) state_nxt = ST_IDLE;
      end
      ST_CPU: begin
        if (IOWrite)            state_nxt = ST_CPU;
        else if (hold_cnt == 32'd0) state_nxt = SwitchCtrl ? ST_SW : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Loading HOLD_CYCLES-1 and leaving on the zero cycle keeps CPU ownership
  // for exactly HOLD_CYCLES cycles after the last write.
  always_comb begin
    hold_cnt_nxt = hold_cnt;
    if (IOWrite)
      hold_cnt_nxt = HOLD_CYCLES - 32'd1;
    else if (state == ST_CPU && hold_cnt != 32'd0)
      hold_cnt_nxt = hold_cnt - 32'd1;
  end

  // The shadow follows the owner the FSM is about to enter, so the value
  // and its owner always line up.
  always_comb begin
    shadow_nxt = shadow;
    if (IOWrite)
      shadow_nxt = io_wdata;
    else if (state_nxt == ST_SW)
      shadow_nxt = {16'h0000, io_read_dataP5R1};
    else if (state_nxt == ST_IDLE)
      shadow_nxt = 32'h0000_0000;
  end

`ifdef SEG_LZB_EN
  // Light every digit up to the most-significant non-zero nibble; digit 0
  // stays lit so a zero value still shows "0".
  always_comb begin
    logic seen;
    seen   = 1'b0;
    en_nxt = 8'h01;
    for (int i = 7; i >= 1; i--) begin
      seen      = seen | (shadow[4*i +: 4] != 4'h0);
      en_nxt[i] = seen;
    end
    if (state == ST_IDLE)
      en_nxt = 8'h00;
  end
`else
  always_comb begin
    en_nxt = (state == ST_IDLE) ? 8'h00 : 8'hFF;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      hold_cnt  <= 32'd0;
      shadow    <= 32'h0000_0000;
      disp_data <= 32'h0000_0000;
      digit_en  <= 8'h00;
      pending   <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
      shadow   <= shadow_nxt;
      // Commit uses the pre-update shadow; a same-cycle change stays pending
      // and goes out on the following frame.
      if (frame_tick) begin
        disp_data <= shadow;
        digit_en  <= en_nxt;
      end
      if (shadow_nxt != shadow)
        pending <= 1'b1;
      else if (frame_tick)
        pending <= 1'b0;
    end
  end

  assign disp_src = state;

endmodule

// File: tb/tb_seg_disp_ctrl.sv
// tb/tb_seg_disp_ctrl.sv - scoreboard bench for seg_disp_ctrl with a cycle-indexed reference model
module tb_seg_disp_ctrl;

  localparam int HOLD = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        SwitchCtrl = 1'b0;
  logic [15:0] io_read_dataP5R1 = 16'h0;
  logic        IOWrite = 1'b0;
  logic [31:0] io_wdata = 32'h0;
  logic        frame_tick = 1'b0;
  logic [31:0] disp_data;
  logic [7:0]  digit_en;
  logic [1:0]  disp_src;
  logic        pending;

  seg_disp_ctrl #(.HOLD_CYCLES(32'(HOLD))) dut (
    .clk              (clk),
    .rst              (rst),
    .SwitchCtrl       (SwitchCtrl),
    .io_read_dataP5R1 (io_read_dataP5R1),
    .IOWrite          (IOWrite),
    .io_wdata         (io_wdata),
    .frame_tick       (frame_tick),
    .disp_data        (disp_data),
    .digit_en         (digit_en),
    .disp_src         (disp_src),
    .pending          (pending)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  en;
    logic [1:0]  src;
    logic        pend;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: ownership derived from the cycle distance to the last write.
  int          cyc    = 0;
  int          last_w = -1000000;
  logic [1:0]  m_owner  = 2'd0;
  logic [31:0] m_shadow = 32'h0;
  logic [31:0] m_disp   = 32'h0;
  logic [7:0]  m_en     = 8'h00;
  logic        m_pend   = 1'b0;

  function automatic logic [7:0] en_for(input logic [1:0] owner, input logic [31:0] val);
`ifdef SEG_LZB_EN
    int top;
    top = 0;
    for (int i = 0; i < 8; i++)
      if (((val >> (4 * i)) & 32'hF) != 32'h0) top = i;
    if (owner == 2'd0) return 8'h00;
    return 8'((1 << (top + 1)) - 1);
`else
    if (owner == 2'd0) return 8'h00;
    return 8'hFF;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc_step(input logic r, input logic s, input logic [15:0] sd,
                          input logic w, input logic [31:0] wd, input logic t);
    int         since;
    logic [1:0] n_owner;
    logic [31:0] n_sh;
    logic       n_pend;
    @(negedge clk);
    rst = r; SwitchCtrl = s; io_read_dataP5R1 = sd;
    IOWrite = w; io_wdata = wd; frame_tick = t;
    if (r) begin
      m_owner = 2'd0; m_shadow = 32'h0; m_disp = 32'h0; m_en = 8'h00;
      m_pend = 1'b0; last_w = -1000000;
    end else begin
      since = cyc - last_w;
      if (w)                               n_owner = 2'd2;
      else if (since >= 1 && since < HOLD) n_owner = 2'd2;
      else if (s)                          n_owner = 2'd1;
      else                                 n_owner = 2'd0;
      if (w)                   n_sh = wd;
      else if (n_owner == 2'd1) n_sh = {16'h0, sd};
      else if (n_owner == 2'd0) n_sh = 32'h0;
      else                      n_sh = m_shadow;
      n_pend = (n_sh != m_shadow) ? 1'b1 : (t ? 1'b0 : m_pend);
      if (t) begin
        m_disp = m_shadow;
        m_en   = en_for(m_owner, m_shadow);
      end
      m_owner = n_owner; m_shadow = n_sh; m_pend = n_pend;
      if (w) last_w = cyc;
    end
    sb_q.push_back('{data: m_disp, en: m_en, src: m_owner, pend: m_pend});
    cyc++;
    if (r) begin
      #1;
      chk("async_rst_data", disp_data, 32'h0);
      chk("async_rst_en", {24'h0, digit_en}, 32'h0);
      chk("async_rst_src", {30'h0, disp_src}, 32'h0);
      chk("async_rst_pend", {31'h0, pending}, 32'h0);
    end
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) cyc_step(1'b0, 1'b0, 16'h0, 1'b0, 32'h0, 1'b0);
  endtask

  // Monitor: every output cycle is compared against the oldest expectation.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_disp_data", disp_data, e.data);
        chk("sb_digit_en", {24'h0, digit_en}, {24'h0, e.en});
        chk("sb_disp_src", {30'h0, disp_src}, {30'h0, e.src});
        chk("sb_pending", {31'h0, pending}, {31'h0, e.pend});
      end
    end
  end

  initial begin
    logic        r_sw;
    logic [15:0] r_sd;
    #1 rst = 1'b1;
    #1;
    chk("reset_data", disp_data, 32'h0);
    chk("reset_src", {30'h0, disp_src}, 32'h0);
    chk("reset_pend", {31'h0, pending}, 32'h0);

    // First tick after reset with no requests leaves reset values.
    cyc_step(1'b0, 1'b0, 16'h0, 1'b0, 32'h0, 1'b1);
    @(posedge clk); #1;
    chk("first_tick_data", disp_data, 32'h0);
    chk("first_tick_en", {24'h0, digit_en}, 32'h0);

    // CPU write, commit five cycles later.
    cyc_step(1'b0, 1'b0, 16'h0, 1'b1, 32'h1234ABCD, 1'b0);
    @(posedge clk); #1;
    chk("wr_src_cpu", {30'h0, disp_src}, 32'h2);
    chk("wr_pending", {31'h0, pending}, 32'h1);
    idle_n(4);
    cyc_step(1'b0, 1'b0, 16'h0, 1'b0, 32'h0, 1'b1);
    @(posedge clk); #1;
    chk("wr_commit", disp_data, 32'h1234ABCD);
    chk("wr_pend_clr", {31'h0, pending}, 32'h0);
    idle_n(4);
    @(posedge clk); #1;
    chk("hold_expired_idle", {30'h0, disp_src}, 32'h0);
    cyc_step(1'b0, 1'b0, 16'h0, 1'b0, 32'h0, 1'b1);

    // Write in the same cycle as a tick: old value goes out, new stays pending.
    cyc_step(1'b0, 1'b0, 16'h0, 1'b1, 32'hA5A50001, 1'b1);
    @(posedge clk); #1;
    chk("same_cycle_old", disp_data, 32'h0);
    chk("same_cycle_pend", {31'h0, pending}, 32'h1);
    cyc_step(1'b0, 1'b0, 16'h0, 1'b0, 32'h0, 1'b1);
    @(posedge clk); #1;
    chk("same_cycle_next", disp_data, 32'hA5A50001);

    // Reset in the middle of a hold.
    idle_n(2);
    cyc_step(1'b1, 1'b0, 16'h0, 1'b0, 32'h0, 1'b0);
    cyc_step(1'b0, 1'b0, 16'h0, 1'b0, 32'h0, 1'b0);

    // Switch echo.
    for (int i = 0; i < 3; i++) cyc_step(1'b0, 1'b1, 16'h00F3, 1'b0, 32'h0, 1'b0);
    cyc_step(1'b0, 1'b1, 16'h00F3, 1'b0, 32'h0, 1'b1);
    @(posedge clk); #1;
    chk("sw_data", disp_data, 32'h000000F3);
`ifdef SEG_LZB_EN
    chk("sw_en", {24'h0, digit_en}, 32'h03);
`else
    chk("sw_en", {24'h0, digit_en}, 32'hFF);
`endif
    // Write while the switch is held, then fall back to the switch.
    cyc_step(1'b0, 1'b1, 16'h00F3, 1'b1, 32'hDEAD0000, 1'b0);
    for (int i = 0; i < 8; i++) cyc_step(1'b0, 1'b1, 16'h0042, 1'b0, 32'h0, 1'b0);
    @(posedge clk); #1;
    chk("sw_after_cpu", {30'h0, disp_src}, 32'h1);

    // Randomized traffic.
    r_sw = 1'b0;
    r_sd = 16'h0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) r_sw = ~r_sw;
      if ($urandom_range(0, 4) == 0) r_sd = 16'($urandom);
      if ($urandom_range(0, 1) == 0 && $urandom_range(0, 3) == 0) r_sd = r_sd & 16'h00FF;
      cyc_step($urandom_range(0, 799) == 0, r_sw, r_sd,
               $urandom_range(0, 15) == 0, $urandom, $urandom_range(0, 5) == 0);
    end
    cyc_step(1'b0, 1'b0, 16'h0, 1'b0, 32'h0, 1'b0);
    @(posedge clk); #3;
    chk("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
